// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX_DATA,
      ST_RX_ACK,
      ST_TX_DATA,
      ST_TX_ACK,
      ST_IGNORE
   } state_t;

   localparam logic [6:0] DEVICE_ADDR_DEFAULT = 7'h66;
   localparam logic [7:0] RESET_DATA_DEFAULT  = 8'h00;

   localparam logic ACK_BIT  = 1'b0;
   localparam logic NACK_BIT = 1'b1;

   // R/W=1 means the target receives (target-centric direction)
   localparam logic RW_TARGET_RX = 1'b1;

endpackage

// File: rtl/i2c_start_stop_detect.sv
// rtl/i2c_start_stop_detect.sv - SDA-edge START/STOP flags, cleared by the next SCL rise
module i2c_start_stop_detect (
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic start_pending,
   output logic stop_pending
);

   // Each flag is a toggle in the SDA domain acknowledged by a copy in the
   // SCL domain, so no flop needs two clocks.
   logic start_tog;
   logic stop_tog;
   logic start_seen;
   logic stop_seen;

   always_ff @(negedge sda or posedge rst) begin
      if (rst) begin
         start_tog <= 1'b0;
      end else if (scl) begin
         start_tog <= ~start_tog;
      end
   end

   always_ff @(posedge sda or posedge rst) begin
      if (rst) begin
         stop_tog <= 1'b0;
      end else if (scl) begin
         stop_tog <= ~stop_tog;
      end
   end

   always_ff @(posedge scl or posedge rst) begin
      if (rst) begin
         start_seen <= 1'b0;
         stop_seen  <= 1'b0;
      end else begin
         start_seen <= start_tog;
         stop_seen  <= stop_tog;
      end
   end

   assign start_pending = start_tog ^ start_seen;
   assign stop_pending  = stop_tog ^ stop_seen;

endmodule

// File: rtl/i2c_top.sv
// rtl/i2c_top.sv - I2C target with fixed address, loopback data register and clock stretch
module i2c_top
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = DEVICE_ADDR_DEFAULT,
   parameter logic [7:0] RESET_DATA  = RESET_DATA_DEFAULT
) (
   input  logic rst,
   inout  wire  scl,
   inout  wire  sda,
   input  logic hold_clock_low
);

   state_t     state, next_state;
   logic [2:0] cnt, next_cnt;
   logic [6:0] shift, next_shift;
   logic [7:0] data_reg, next_data;
   logic       rw, next_rw;
   logic       after_ack, next_after_ack;
   logic       sda_low;
   logic       stretch_q;
   logic       start_pending;
   logic       stop_pending;

   i2c_start_stop_detect u_detect (
      .rst           (rst),
      .scl           (scl),
      .sda           (sda),
      .start_pending (start_pending),
      .stop_pending  (stop_pending)
   );

   always_ff @(posedge scl or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         shift     <= 7'd0;
         data_reg  <= RESET_DATA;
         rw        <= 1'b0;
         after_ack <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         shift     <= next_shift;
         data_reg  <= next_data;
         rw        <= next_rw;
         after_ack <= next_after_ack;
      end
   end

   // A pending START means this rising edge already carries address bit 1.
   always_comb begin
      next_state     = state;
      next_cnt       = cnt;
      next_shift     = {shift[5:0], sda};
      next_data      = data_reg;
      next_rw        = rw;
      next_after_ack = 1'b0;
      if (start_pending) begin
         next_state = ST_ADDR;
         next_cnt   = 3'd1;
      end else if (stop_pending) begin
         next_state = ST_IDLE;
         next_cnt   = 3'd0;
      end else begin
         case (state)
            ST_ADDR: begin
               next_cnt = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  if (shift == DEVICE_ADDR) begin
                     next_state = ST_ADDR_ACK;
                     next_rw    = sda;
                  end else begin
                     next_state = ST_IGNORE;
                  end
               end
            end
            ST_ADDR_ACK: begin
               next_after_ack = 1'b1;
               next_cnt       = 3'd0;
               next_state     = (rw == RW_TARGET_RX) ? ST_RX_DATA : ST_TX_DATA;
            end
            ST_RX_DATA: begin
               next_cnt = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  next_state = ST_RX_ACK;
                  next_data  = {shift, sda};
               end
            end
            ST_RX_ACK: begin
               next_after_ack = 1'b1;
               next_cnt       = 3'd0;
               next_state     = ST_RX_DATA;
            end
            ST_TX_DATA: begin
               next_cnt = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  next_state = ST_TX_ACK;
               end
            end
            ST_TX_ACK: begin
               next_after_ack = 1'b1;
               next_cnt       = 3'd0;
               next_state     = (sda == ACK_BIT) ? ST_TX_DATA : ST_IGNORE;
            end
            default: begin
            end
         endcase
      end
   end

   // SDA only changes on SCL falling edges, so it is stable while SCL is high.
   always_ff @(negedge scl or posedge rst) begin
      if (rst) begin
         sda_low   <= 1'b0;
         stretch_q <= 1'b0;
      end else begin
         stretch_q <= after_ack & hold_clock_low;
         if (start_pending || stop_pending) begin
            sda_low <= 1'b0;
         end else begin
            case (state)
               ST_ADDR_ACK, ST_RX_ACK: sda_low <= 1'b1;
               ST_TX_DATA:             sda_low <= ~data_reg[3'd7 - cnt];
               default:                sda_low <= 1'b0;
            endcase
         end
      end
   end

   assign sda = sda_low ? 1'b0 : 1'bz;
   assign scl = (stretch_q & after_ack & hold_clock_low) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_top.sv
// tb/tb_i2c_top.sv - randomized controller-side bench for i2c_top
module tb_i2c_top;

   localparam int         Q   = 5;
   localparam logic [6:0] DEV = 7'h66;

   wire  scl;
   wire  sda;
   logic rst;
   logic hold_clock_low;
   logic scl_drv_low;
   logic sda_drv_low;

   pullup (scl);
   pullup (sda);
   assign scl = scl_drv_low ? 1'b0 : 1'bz;
   assign sda = sda_drv_low ? 1'b0 : 1'bz;

   i2c_top dut (
      .rst            (rst),
      .scl            (scl),
      .sda            (sda),
      .hold_clock_low (hold_clock_low)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] model_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_scl_high();
      int t = 0;
      while (scl !== 1'b1 && t < 200) begin
         #1;
         t++;
      end
      if (scl !== 1'b1) check("scl_release_timeout", 32'(scl), 32'd1);
   endtask

   task automatic clock_bit(input logic b, output logic s);
      sda_drv_low = ~b;
      #Q;
      scl_drv_low = 1'b0;
      wait_scl_high();
      #Q;
      s = sda;
      #Q;
      scl_drv_low = 1'b1;
      #Q;
   endtask

   task automatic start_cond();
      sda_drv_low = 1'b0;
      #Q;
      scl_drv_low = 1'b0;
      wait_scl_high();
      #Q;
      sda_drv_low = 1'b1;
      #Q;
      scl_drv_low = 1'b1;
      #Q;
   endtask

   task automatic stop_cond();
      sda_drv_low = 1'b1;
      #Q;
      scl_drv_low = 1'b0;
      wait_scl_high();
      #Q;
      sda_drv_low = 1'b0;
      #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic ctrl_nack, output logic [7:0] got);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         got[i] = s;
      end
      clock_bit(ctrl_nack, s);
   endtask

   // Reference behaviour: matching address is ACKed; R/W=1 stores bytes,
   // R/W=0 returns the stored byte until the controller NACKs.
   task automatic txn(input logic [6:0] addr, input logic rw, input int nbytes, input bit with_stop);
      logic       ack;
      logic [7:0] b;
      logic [7:0] got;
      start_cond();
      send_byte({addr, rw}, ack);
      check("addr_ack", 32'(ack), (addr == DEV) ? 32'd0 : 32'd1);
      if (addr != DEV) begin
         b = 8'($urandom);
         send_byte(b, ack);
         check("ignored_ack", 32'(ack), 32'd1);
      end else if (rw) begin
         for (int k = 0; k < nbytes; k++) begin
            b = 8'($urandom);
            send_byte(b, ack);
            check("rx_ack", 32'(ack), 32'd0);
            model_data = b;
         end
      end else begin
         for (int k = 0; k < nbytes; k++) begin
            read_byte(k == nbytes - 1, got);
            check("tx_data", 32'(got), 32'(model_data));
         end
         read_byte(1'b1, got);
         check("after_nack", 32'(got), 32'hff);
      end
      if (with_stop) stop_cond();
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] got;
      logic [7:0] b;

      rst            = 1'b1;
      hold_clock_low = 1'b0;
      scl_drv_low    = 1'b0;
      sda_drv_low    = 1'b0;
      model_data     = 8'h00;
      #20;
      check("reset_scl", 32'(scl), 32'd1);
      check("reset_sda", 32'(sda), 32'd1);
      rst = 1'b0;
      #10;

      // write 0xAB
      start_cond();
      send_byte({DEV, 1'b1}, ack);
      check("wr_addr_ack", 32'(ack), 32'd0);
      send_byte(8'hAB, ack);
      check("wr_data_ack", 32'(ack), 32'd0);
      model_data = 8'hAB;

      // repeated START then STOP
      start_cond();
      send_byte({DEV, 1'b1}, ack);
      check("rs_addr_ack", 32'(ack), 32'd0);
      stop_cond();
      check("stop_sda", 32'(sda), 32'd1);

      // read back, ACK then NACK
      start_cond();
      send_byte({DEV, 1'b0}, ack);
      check("rd_addr_ack", 32'(ack), 32'd0);
      read_byte(1'b0, got);
      check("rd_byte0", 32'(got), 32'hAB);
      read_byte(1'b1, got);
      check("rd_byte1", 32'(got), 32'hAB);
      read_byte(1'b1, got);
      check("rd_after_nack", 32'(got), 32'hFF);
      stop_cond();

      // wrong address
      start_cond();
      send_byte({7'h26, 1'b1}, ack);
      check("bad_addr_nack", 32'(ack), 32'd1);
      send_byte(8'h00, ack);
      check("bad_addr_data", 32'(ack), 32'd1);
      stop_cond();
      txn(DEV, 1'b0, 1, 1'b1);

      // clock stretch after the data ACK
      start_cond();
      send_byte({DEV, 1'b1}, ack);
      check("cs_addr_ack", 32'(ack), 32'd0);
      b = 8'h3C;
      clock_bit(b[7], s);
      clock_bit(b[6], s);
      hold_clock_low = 1'b1;
      for (int i = 5; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
      check("cs_data_ack", 32'(ack), 32'd0);
      model_data = b;
      scl_drv_low = 1'b0;
      #Q;
      check("cs_held", 32'(scl), 32'd0);
      #100;
      check("cs_still_held", 32'(scl), 32'd0);
      hold_clock_low = 1'b0;
      #1;
      check("cs_released", 32'(scl), 32'd1);
      #Q;
      scl_drv_low = 1'b1;
      #Q;
      stop_cond();
      txn(DEV, 1'b0, 1, 1'b1);

      // reset during RX bit 4
      start_cond();
      send_byte({DEV, 1'b1}, ack);
      check("rm_addr_ack", 32'(ack), 32'd0);
      b = 8'h5A;
      for (int i = 7; i >= 5; i--) clock_bit(b[i], s);
      sda_drv_low = ~b[4];
      #Q;
      scl_drv_low = 1'b0;
      #Q;
      rst = 1'b1;
      #1;
      sda_drv_low = 1'b0;
      #1;
      check("rm_sda_released", 32'(sda), 32'd1);
      scl_drv_low = 1'b1;
      #Q;
      rst = 1'b0;
      model_data = 8'h00;
      #Q;
      txn(DEV, 1'b0, 1, 1'b1);

      // randomized transactions
      for (int n = 0; n < 30; n++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV;
         txn(a, 1'($urandom), int'($urandom_range(1, 3)), 1'($urandom));
      end
      stop_cond();
      txn(DEV, 1'b0, 2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
